// File: rtl/lector_contadores.sv
// Readout sequencer for the per-FIFO push counter block.
// It fetches the four FIFO counts in order, keeps them and their sum, then pulses done.
module lector_contadores #(
  parameter int CBITS   = 5,
  parameter int TBITS   = 3,
  parameter int TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             idle,
  input  logic [CBITS-1:0] counter_in,
  input  logic             valid_in,
  output logic             req,
  output logic [1:0]       idx,
  output logic [CBITS-1:0] count0,
  output logic [CBITS-1:0] count1,
  output logic [CBITS-1:0] count2,
  output logic [CBITS-1:0] count3,
  output logic [CBITS+1:0] total,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [1:0] {ESPERA, PIDE, PAUSA, FIN} state_t;

  state_t           state, next_state;
  logic [TBITS-1:0] timer;
  logic             abort, accept, expired, advance;
  logic             req_d, busy_d, done_d;
  logic [CBITS-1:0] capture;

  // Losing idle takes priority over a valid arriving in the same cycle.
  assign abort   = ((state == PIDE) || (state == PAUSA)) && !idle;
  assign accept  = (state == PIDE) && idle && valid_in;
  assign expired = (state == PIDE) && idle && !valid_in && (timer == TBITS'(TIMEOUT - 1));
  assign advance = accept || expired;
  assign capture = accept ? counter_in : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ESPERA;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ESPERA: if (start && idle) next_state = PIDE;
      PIDE: begin
        if (!idle)        next_state = ESPERA;
        else if (advance) next_state = (idx == 2'd3) ? FIN : PAUSA;
      end
      PAUSA:   next_state = idle ? PIDE : ESPERA;
      FIN:     next_state = ESPERA;
      default: next_state = ESPERA;
    endcase
  end

  // Control outputs are decoded from the upcoming state so they register in step with it.
  always_comb begin
    req_d  = (next_state == PIDE);
    busy_d = (next_state != ESPERA);
    done_d = (next_state == FIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      idx    <= 2'd0;
      timer  <= '0;
      total  <= '0;
      error  <= 1'b0;
      count0 <= '0;
      count1 <= '0;
      count2 <= '0;
      count3 <= '0;
    end else begin
      req  <= req_d;
      busy <= busy_d;
      done <= done_d;
      case (state)
        ESPERA: begin
          if (start && idle) begin
            idx   <= 2'd0;
            timer <= '0;
            total <= '0;
            error <= 1'b0;
          end
        end
        PIDE: begin
          if (abort) begin
            error <= 1'b1;
            idx   <= 2'd0;
          end else if (advance) begin
            case (idx)
              2'd0:    count0 <= capture;
              2'd1:    count1 <= capture;
              2'd2:    count2 <= capture;
              default: count3 <= capture;
            endcase
            total <= total + {2'b00, capture};
            timer <= '0;
            if (expired) error <= 1'b1;
          end else begin
            timer <= timer + TBITS'(1);
          end
        end
        PAUSA: begin
          timer <= '0;
          if (abort) begin
            error <= 1'b1;
            idx   <= 2'd0;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        FIN:     idx <= 2'd0;
        default: idx <= 2'd0;
      endcase
    end
  end

endmodule
